decode_ibuf_stage: RTL and testbench

//  Parametrised successor of the fetch->decode pipe register. Replaces the single stall-held

---
 rtl/decode_ibuf_stage_pkg.sv | 63 ++++++
 rtl/decode_ibuf_stage_if.sv | 49 ++++
 rtl/decode_ibuf_stage_fifo.sv | 56 +++++
 rtl/decode_ibuf_stage.sv | 83 ++++++++
 tb/tb_decode_ibuf_stage.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/decode_ibuf_stage_pkg.sv
// Shared decode definitions: NOP, opcodes, field layout and RV32I immediate helpers.
package decode_ibuf_stage_pkg;

    // Immediates are built at this width and truncated to XLEN by the user,
    // which keeps the sign extension correct for any XLEN up to IMM_W.
    localparam int unsigned IMM_W = 64;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b000_0011,
        OPC_OP_IMM = 7'b001_0011,
        OPC_AUIPC  = 7'b001_0111,
        OPC_STORE  = 7'b010_0011,
        OPC_OP     = 7'b011_0011,
        OPC_LUI    = 7'b011_0111,
        OPC_BRANCH = 7'b110_0011,
        OPC_JALR   = 7'b110_0111,
        OPC_JAL    = 7'b110_1111,
        OPC_SYSTEM = 7'b111_0011
    } rv_opcode_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] csr_addr;
    } instr_fields_t;

    function automatic instr_fields_t decode_fields(input logic [31:0] instr);
        instr_fields_t f;
        f.opcode   = instr[6:0];
        f.funct3   = instr[14:12];
        f.rs1      = instr[19:15];
        f.rs2      = instr[24:20];
        f.rd       = instr[11:7];
        f.csr_addr = instr[31:20];
        return f;
    endfunction

    function automatic logic [IMM_W-1:0] imm_i(input logic [31:0] instr);
        return {{(IMM_W-12){instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [IMM_W-1:0] imm_s(input logic [31:0] instr);
        return {{(IMM_W-12){instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [IMM_W-1:0] imm_b(input logic [31:0] instr);
        return {{(IMM_W-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [IMM_W-1:0] imm_u(input logic [31:0] instr);
        return {{(IMM_W-32){instr[31]}}, instr[31:12], 12'b0};
    endfunction

    function automatic logic [IMM_W-1:0] imm_j(input logic [31:0] instr);
        return {{(IMM_W-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/decode_ibuf_stage_if.sv
// Fetch-side and issue-side handshake bundle of the decode instruction buffer.
interface decode_ibuf_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] pc_i;
    logic [31:0]     instr_i;
    logic            misaligned_i;
    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] pc_o;
    logic [31:0]     instr_o;
    logic            misaligned_o;
    logic [6:0]      opcode_o;
    logic [2:0]      funct3_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;
    logic [4:0]      rd_o;
    logic [11:0]     csr_addr_o;
    logic [XLEN-1:0] i_imm;
    logic [XLEN-1:0] s_imm;
    logic [XLEN-1:0] b_imm;
    logic [XLEN-1:0] u_imm;
    logic [XLEN-1:0] j_imm;
    logic [CW-1:0]   count_o;
    logic            almost_full;

    // Driver side: fetch, redirect and issue consumer.
    modport master (
        output in_valid, pc_i, instr_i, misaligned_i, flush, out_ready,
        input  in_ready, out_valid, pc_o, instr_o, misaligned_o,
               opcode_o, funct3_o, rs1_o, rs2_o, rd_o, csr_addr_o,
               i_imm, s_imm, b_imm, u_imm, j_imm, count_o, almost_full
    );

    // Buffer side.
    modport slave (
        input  in_valid, pc_i, instr_i, misaligned_i, flush, out_ready,
        output in_ready, out_valid, pc_o, instr_o, misaligned_o,
               opcode_o, funct3_o, rs1_o, rs2_o, rd_o, csr_addr_o,
               i_imm, s_imm, b_imm, u_imm, j_imm, count_o, almost_full
    );
endinterface

// File: rtl/decode_ibuf_stage_fifo.sv
// Generic FIFO: unreset storage, wrapping pointers, occupancy count, synchronous clear.
module ibuf_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage write; contents are left unreset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy update; clear wins over any concurrent push/pop.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/decode_ibuf_stage.sv
// Fetch->decode instruction buffer with head-entry field and immediate decode.
module decode_ibuf_stage
    import decode_ibuf_stage_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = 3
) (
    input  logic                 clk,
    input  logic                 nrst,
    decode_ibuf_stage_if.slave   bus
);
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned WIDTH = XLEN + 33;

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;

    logic [XLEN-1:0]  head_pc;
    logic [31:0]      head_instr;
    logic             head_mis;
    instr_fields_t    fields;

    // Handshake decode from the registered count only.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = bus.in_valid & ~full & ~bus.flush;
    assign pop   = ~empty & bus.out_ready & ~bus.flush;
    assign wdata = {bus.misaligned_i, bus.instr_i, bus.pc_i};

    ibuf_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .wr_en (push),
        .rd_en (pop),
        .clr   (bus.flush),
        .wdata (wdata),
        .rdata (rdata),
        .count (count)
    );

    // Head entry, replaced by a NOP bubble while the buffer is empty.
    always_comb begin
        head_pc    = '0;
        head_instr = NOP_INSTR;
        head_mis   = 1'b0;
        if (!empty) begin
            head_pc    = rdata[XLEN-1:0];
            head_instr = rdata[XLEN+31:XLEN];
            head_mis   = rdata[XLEN+32];
        end
    end

    assign fields = decode_fields(head_instr);

    assign bus.in_ready     = ~full;
    assign bus.out_valid    = ~empty;
    assign bus.pc_o         = head_pc;
    assign bus.instr_o      = head_instr;
    assign bus.misaligned_o = head_mis;
    assign bus.opcode_o     = fields.opcode;
    assign bus.funct3_o     = fields.funct3;
    assign bus.rs1_o        = fields.rs1;
    assign bus.rs2_o        = fields.rs2;
    assign bus.rd_o         = fields.rd;
    assign bus.csr_addr_o   = fields.csr_addr;
    assign bus.i_imm        = XLEN'(imm_i(head_instr));
    assign bus.s_imm        = XLEN'(imm_s(head_instr));
    assign bus.b_imm        = XLEN'(imm_b(head_instr));
    assign bus.u_imm        = XLEN'(imm_u(head_instr));
    assign bus.j_imm        = XLEN'(imm_j(head_instr));
    assign bus.count_o      = count;
    assign bus.almost_full  = (count >= CW'(AF_LEVEL));

endmodule

// File: tb/tb_decode_ibuf_stage.sv
// Scoreboard bench for decode_ibuf_stage: directed stimulus, decoupled output monitor.
module tb_decode_ibuf_stage;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AFL   = 3;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    logic clk;
    logic nrst;
    int   checks;
    int   failures;
    int   mcount;
    exp_t sb[$];

    decode_ibuf_stage_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    decode_ibuf_stage #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AFL)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (nrst && bus.out_valid && bus.out_ready && !bus.flush) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pop", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pop_pc", bus.pc_o, e.pc);
                chk("pop_instr", bus.instr_o, e.instr);
                chk("pop_mis", 32'(bus.misaligned_o), 32'(e.mis));
            end
        end
    end

    // One clock of stimulus, entered and left at posedge+1; checks status against the model.
    task automatic cyc(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic mis, input logic ordy, input logic fl);
        logic p;
        logic q;
        exp_t e;
        bus.in_valid     = iv;
        bus.pc_i         = pc;
        bus.instr_i      = ins;
        bus.misaligned_i = mis;
        bus.out_ready    = ordy;
        bus.flush        = fl;
        #1;
        chk("count", 32'(bus.count_o), 32'(mcount));
        chk("in_ready", 32'(bus.in_ready), (mcount < DEPTH) ? 32'd1 : 32'd0);
        chk("out_valid", 32'(bus.out_valid), (mcount != 0) ? 32'd1 : 32'd0);
        chk("almost_full", 32'(bus.almost_full), (mcount >= AFL) ? 32'd1 : 32'd0);
        if (mcount == 0) begin
            chk("empty_instr_nop", bus.instr_o, NOP);
            chk("empty_mis", 32'(bus.misaligned_o), 32'd0);
            chk("empty_i_imm", bus.i_imm, 32'd0);
        end
        p = iv && (mcount < DEPTH) && !fl;
        q = (mcount != 0) && ordy && !fl;
        if (fl) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (p) begin
                e.pc = pc; e.instr = ins; e.mis = mis;
                sb.push_back(e);
            end
            mcount = mcount + (p ? 1 : 0) - (q ? 1 : 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        checks = 0; failures = 0; mcount = 0;
        nrst = 1'b0;
        bus.in_valid = 1'b0; bus.pc_i = '0; bus.instr_i = '0; bus.misaligned_i = 1'b0;
        bus.out_ready = 1'b0; bus.flush = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_instr", bus.instr_o, NOP);
        chk("rst_pc", bus.pc_o, 32'd0);
        chk("rst_count", 32'(bus.count_o), 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;

        // 1: single push, visible next cycle
        cyc(1'b1, 32'h100, 32'h00A0_0093, 1'b0, 1'b0, 1'b0);
        chk("t1_rd", 32'(bus.rd_o), 32'd1);
        chk("t1_i_imm", bus.i_imm, 32'd10);
        chk("t1_pc", bus.pc_o, 32'h100);
        chk("t1_opcode", 32'(bus.opcode_o), 32'h13);
        idle(1'b1);

        // 2: fill, overflow attempt, drain in order
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h200 + 32'(i * 4), 32'h0000_0093 | (32'(i + 1) << 20), i[0], 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) idle(1'b1);

        // 3: steady push+pop at count 1, pointers wrap several times
        cyc(1'b1, 32'h400, 32'h0000_0113, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 32'h404 + 32'(i * 4), 32'h13 | (32'(i) << 7), i[0], 1'b1, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);

        // 4: flush at count 3 with concurrent input
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h600 + 32'(i * 4), 32'h0000_0213, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hDEAD, 32'h0000_0EEF, 1'b1, 1'b1, 1'b1);
        chk("t4_instr_nop", bus.instr_o, NOP);
        idle(1'b1);
        cyc(1'b1, 32'h700, 32'h0000_0313, 1'b0, 1'b0, 1'b0);
        chk("t4_head_after_flush", bus.pc_o, 32'h700);
        idle(1'b1);

        // 5: immediate decode
        cyc(1'b1, 32'h800, 32'hFE00_0EE3, 1'b0, 1'b0, 1'b0);
        chk("t5_b_imm", bus.b_imm, 32'hFFFF_FFFC);
        chk("t5_i_imm", bus.i_imm, 32'hFFFF_FFE0);
        chk("t5_s_imm", bus.s_imm, 32'hFFFF_FFFD);
        chk("t5_csr", 32'(bus.csr_addr_o), 32'hFE0);
        chk("t5_opcode", 32'(bus.opcode_o), 32'h63);
        idle(1'b1);
        cyc(1'b1, 32'h804, 32'h8000_00EF, 1'b0, 1'b0, 1'b0);
        chk("t5_j_imm", bus.j_imm, 32'hFFF0_0000);
        chk("t5_rd", 32'(bus.rd_o), 32'd1);
        idle(1'b1);
        cyc(1'b1, 32'h808, 32'hFFFF_F2B7, 1'b0, 1'b0, 1'b0);
        chk("t5_u_imm", bus.u_imm, 32'hFFFF_F000);
        chk("t5_rd_u", 32'(bus.rd_o), 32'd5);
        idle(1'b1);

        // 6: asynchronous reset mid-stream at count 2
        cyc(1'b1, 32'h900, 32'h0000_0413, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h904, 32'h0000_0513, 1'b1, 1'b0, 1'b0);
        chk("t6_count_before", 32'(bus.count_o), 32'd2);
        #2;
        nrst = 1'b0;
        #1;
        chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_count", 32'(bus.count_o), 32'd0);
        chk("t6_instr", bus.instr_o, NOP);
        chk("t6_mis", 32'(bus.misaligned_o), 32'd0);
        chk("t6_pc", bus.pc_o, 32'd0);
        chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t6_almost_full", 32'(bus.almost_full), 32'd0);
        sb.delete();
        mcount = 0;
        @(posedge clk); #1;
        nrst = 1'b1;
        cyc(1'b1, 32'hA00, 32'h0000_0613, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
